// File: rtl/fir_tap_scheduler.sv
// Time-multiplexed 24-tap FIR controller: one shared MAC walks the delay line
// one tap per clock, then applies the runtime gain and the overflow-zero rule.
module fir_tap_scheduler #(
    parameter int NTAPS     = 24,
    parameter int DW        = 8,
    parameter int CW        = 12,
    parameter int ACCW      = 24,
    parameter int GW        = 8,
    parameter int SAT_LIMIT = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic signed [DW-1:0]   s_data,
    input  logic                   cfg_we,
    input  logic [4:0]             cfg_addr,
    input  logic signed [CW-1:0]   cfg_data,
    input  logic [GW-1:0]          gain,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic signed [ACCW-1:0] m_data,
    output logic                   busy,
    output logic                   ovf,
    output logic                   cfg_err
);

    localparam int PW = DW + CW;
    localparam int YW = ACCW + GW + 1;
    localparam logic [4:0] NTAPS_A = 5'(NTAPS);
    localparam logic [4:0] LAST_IDX = 5'(NTAPS - 1);
    localparam logic signed [YW-1:0] SAT_POS = YW'(SAT_LIMIT);
    localparam logic signed [YW-1:0] SAT_NEG = -SAT_POS;

    typedef enum logic [1:0] {IDLE, MAC, SCALE, OUT} state_t;

    state_t                 state_q, state_d;
    logic signed [DW-1:0]   x_q    [NTAPS];
    logic signed [CW-1:0]   coef_q [NTAPS];
    logic signed [ACCW-1:0] acc_q;
    logic [4:0]             idx_q;
    logic                   m_valid_q, ovf_q, cfg_err_q;
    logic signed [ACCW-1:0] m_data_q;

    logic                   accept, cfg_ok, last_tap, sat;
    logic signed [PW-1:0]   prod;
    logic signed [YW-1:0]   acc_ext, gain_ext, y;

    // Symmetric default response; only the first half is tabulated.
    function automatic logic signed [CW-1:0] default_coef(input int i);
        int h;
        h = (i < NTAPS / 2) ? i : NTAPS - 1 - i;
        case (h)
            0:       return CW'(3);
            1:       return CW'(7);
            2:       return CW'(8);
            3:       return CW'(10);
            4:       return CW'(-16);
            5:       return CW'(-37);
            6:       return CW'(-49);
            7:       return CW'(-33);
            8:       return CW'(21);
            9:       return CW'(106);
            10:      return CW'(194);
            11:      return CW'(251);
            default: return '0;
        endcase
    endfunction

    assign accept   = (state_q == IDLE) && s_valid;
    assign cfg_ok   = cfg_we && (state_q == IDLE) && (cfg_addr < NTAPS_A);
    assign last_tap = (idx_q == LAST_IDX);
    assign prod     = PW'(coef_q[idx_q]) * PW'(x_q[idx_q]);
    assign acc_ext  = YW'(acc_q);
    assign gain_ext = YW'({1'b0, gain});
    assign y        = acc_ext * gain_ext;
    assign sat      = (y > SAT_POS) || (y < SAT_NEG);

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        busy    = 1'b1;
        case (state_q)
            IDLE: begin
                s_ready = 1'b1;
                busy    = 1'b0;
                if (s_valid) state_d = MAC;
            end
            MAC:     if (last_tap) state_d = SCALE;
            SCALE:   state_d = OUT;
            OUT:     if (m_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NTAPS; gi++) begin : g_tap
            always_ff @(posedge clk) begin
                if (!rst) begin
                    x_q[gi]    <= '0;
                    coef_q[gi] <= default_coef(gi);
                end else begin
                    if (accept) begin
                        if (gi == 0) x_q[gi] <= s_data;
                        else         x_q[gi] <= x_q[(gi == 0) ? 0 : gi - 1];
                    end
                    if (cfg_ok && (cfg_addr == 5'(gi))) coef_q[gi] <= cfg_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q     <= '0;
            idx_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            ovf_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            ovf_q     <= 1'b0;
            cfg_err_q <= cfg_we && !cfg_ok;
            case (state_q)
                IDLE: begin
                    if (s_valid) begin
                        acc_q <= '0;
                        idx_q <= '0;
                    end
                end
                MAC: begin
                    acc_q <= acc_q + ACCW'(prod);
                    idx_q <= idx_q + 5'd1;
                end
                SCALE: begin
                    // |y| <= SAT_LIMIT fits in ACCW, so truncation is exact
                    m_data_q  <= sat ? '0 : y[ACCW-1:0];
                    ovf_q     <= sat;
                    m_valid_q <= 1'b1;
                end
                OUT:     if (m_ready) m_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign ovf     = ovf_q;
    assign cfg_err = cfg_err_q;

endmodule
